// File: rtl/gray_pkg.sv
// Shared helpers for the Gray-code counter family.
//   bin2gray  : binary -> reflected Gray encoding. It works on a
//               GRAY_MAX_W-bit vector. Callers zero-extend their SIZE-bit
//               value and keep the low SIZE bits. The top bit of a Gray code
//               equals the top binary bit, so the zero padding above SIZE
//               never leaks into the kept bits.
//   max_count : all-ones terminal count 2^size-1 for a given width.
package gray_pkg;

    localparam int GRAY_MAX_W = 32;

    function automatic logic [GRAY_MAX_W-1:0] bin2gray(input logic [GRAY_MAX_W-1:0] b);
        return b ^ (b >> 1);
    endfunction

    function automatic logic [GRAY_MAX_W-1:0] max_count(input int size);
        if (size >= GRAY_MAX_W)
            return '1;
        return (GRAY_MAX_W'(1) << size) - GRAY_MAX_W'(1);
    endfunction

endpackage

// File: rtl/gray_counter_bin2gray.sv
// Purely combinational binary-to-Gray encoder. It is the inverse of the
// Gray-to-binary decoder.
//   bin_i  [SIZE-1:0] : binary input
//   gray_o [SIZE-1:0] : Gray encoding, gray[i] = bin[i+1] ^ bin[i]
module bin2gray #(
    parameter int SIZE = 8
) (
    input  logic [SIZE-1:0] bin_i,
    output logic [SIZE-1:0] gray_o
);

    localparam int W = gray_pkg::GRAY_MAX_W;

    logic [W-1:0] gray_wide;

    assign gray_wide = gray_pkg::bin2gray(W'(bin_i));
    assign gray_o    = gray_wide[SIZE-1:0];

endmodule

// File: rtl/gray_counter.sv
// Registered up/down Gray-code counter with parallel binary load and a
// wrap pulse.
//   clk      : rising-edge clock
//   rst      : synchronous active-high reset, clears all outputs
//   en       : step enable, one step per cycle
//   up       : step direction, 1 = increment, 0 = decrement
//   load     : parallel load of load_bin. It overrides en.
//   load_bin : binary value to load
//   gray     : registered Gray code of the current count
//   bin      : registered binary count
//   wrap     : one-cycle pulse after an en step that wraps the count
// Priority is rst > load > en > hold.
module gray_counter
    import gray_pkg::*;
#(
    parameter int SIZE = 8
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            en,
    input  logic            up,
    input  logic            load,
    input  logic [SIZE-1:0] load_bin,
    output logic [SIZE-1:0] gray,
    output logic [SIZE-1:0] bin,
    output logic            wrap
);

    localparam logic [SIZE-1:0] MAX_CNT = SIZE'(max_count(SIZE));

    logic [SIZE-1:0] cnt_q,  cnt_d;
    logic [SIZE-1:0] gray_q, gray_d;
    logic            wrap_q, wrap_d;

    always_comb begin
        cnt_d  = cnt_q;
        wrap_d = 1'b0;
        if (load) begin
            cnt_d = load_bin;
        end else if (en) begin
            if (up) begin
                cnt_d  = cnt_q + SIZE'(1);
                wrap_d = (cnt_q == MAX_CNT);
            end else begin
                cnt_d  = cnt_q - SIZE'(1);
                wrap_d = (cnt_q == '0);
            end
        end
    end

    // Encode the next count, not the current one. This keeps gray aligned
    // with bin in the same cycle and avoids a combinational output path.
    bin2gray #(.SIZE(SIZE)) u_enc (
        .bin_i  (cnt_d),
        .gray_o (gray_d)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q  <= '0;
            gray_q <= '0;
            wrap_q <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            gray_q <= gray_d;
            wrap_q <= wrap_d;
        end
    end

    assign bin  = cnt_q;
    assign gray = gray_q;
    assign wrap = wrap_q;

endmodule

// File: tb/tb_gray_counter.sv
// Self-checking bench for gray_counter with SIZE=5. Each driven cycle pushes
// the reference outcome to a scoreboard queue. That outcome is popped and
// compared one edge later, when the DUT presents it.
module tb_gray_counter;

    localparam int SIZE = 5;

    typedef struct packed {
        logic [SIZE-1:0] bin;
        logic [SIZE-1:0] gray;
        logic            wrap;
    } exp_t;

    logic            clk = 1'b0;
    logic            rst = 1'b0;
    logic            en = 1'b0;
    logic            up = 1'b0;
    logic            load = 1'b0;
    logic [SIZE-1:0] load_bin = '0;
    logic [SIZE-1:0] gray;
    logic [SIZE-1:0] bin;
    logic            wrap;

    int   checks = 0;
    int   errors = 0;
    exp_t sb[$];
    logic [SIZE-1:0] m_cnt = '0;

    gray_counter #(.SIZE(SIZE)) dut (
        .clk      (clk),
        .rst      (rst),
        .en       (en),
        .up       (up),
        .load     (load),
        .load_bin (load_bin),
        .gray     (gray),
        .bin      (bin),
        .wrap     (wrap)
    );

    always #5 clk = ~clk;

    // Bitwise reference encoder.
    function automatic logic [SIZE-1:0] ref_enc(input logic [SIZE-1:0] b);
        logic [SIZE-1:0] g;
        g[SIZE-1] = b[SIZE-1];
        for (int i = 0; i < SIZE-1; i++) g[i] = b[i+1] ^ b[i];
        return g;
    endfunction

    // Reference Gray-to-binary decoder.
    function automatic logic [SIZE-1:0] ref_dec(input logic [SIZE-1:0] g);
        logic [SIZE-1:0] b;
        b[SIZE-1] = g[SIZE-1];
        for (int i = SIZE-2; i >= 0; i--) b[i] = b[i+1] ^ g[i];
        return b;
    endfunction

    // Drive one cycle, push the model result, then advance to #1 after the edge.
    task automatic drive(input logic r, input logic l, input logic e,
                         input logic u, input logic [SIZE-1:0] lb);
        exp_t x;
        rst = r; load = l; en = e; up = u; load_bin = lb;
        x.wrap = 1'b0;
        if (r) begin
            m_cnt = '0;
        end else if (l) begin
            m_cnt = lb;
        end else if (e) begin
            if (u) begin
                x.wrap = (m_cnt == 5'd31);
                m_cnt  = m_cnt + 5'd1;
            end else begin
                x.wrap = (m_cnt == 5'd0);
                m_cnt  = m_cnt - 5'd1;
            end
        end
        x.bin  = m_cnt;
        x.gray = ref_enc(m_cnt);
        sb.push_back(x);
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        exp_t x;
        for (int i = 0; i < 2; i++) begin
            drive(1'b1, 1'b0, 1'b1, 1'b1, '0);
            x = sb.pop_front();
            checks++;
            if ({bin, gray, wrap} !== x) begin
                errors++;
                $display("FAIL reset[%0d]: got bin=%b gray=%b wrap=%b, want %b/%b/%b",
                         i, bin, gray, wrap, x.bin, x.gray, x.wrap);
            end
            checks++;
            if ({bin, gray, wrap} !== 11'b0) begin
                errors++;
                $display("FAIL reset_zero[%0d]: got %b/%b/%b, want all zero", i, bin, gray, wrap);
            end
        end
        drive(1'b0, 1'b0, 1'b1, 1'b1, '0);
        x = sb.pop_front();
        checks++;
        if (bin !== 5'b00001 || gray !== 5'b00001 || {bin, gray, wrap} !== x) begin
            errors++;
            $display("FAIL first_step: got bin=%b gray=%b, want 00001/00001", bin, gray);
        end
    endtask

    task automatic test_up_wrap();
        exp_t x;
        logic [SIZE-1:0] exp_g [4] = '{5'b10001, 5'b10000, 5'b00000, 5'b00001};
        logic            exp_w [4] = '{1'b0, 1'b0, 1'b1, 1'b0};
        for (int i = 0; i < 4; i++) begin
            if (i == 0) drive(1'b0, 1'b1, 1'b0, 1'b0, 5'd30);
            else        drive(1'b0, 1'b0, 1'b1, 1'b1, '0);
            x = sb.pop_front();
            checks++;
            if (gray !== exp_g[i] || wrap !== exp_w[i] || {bin, gray, wrap} !== x) begin
                errors++;
                $display("FAIL up_wrap[%0d]: got bin=%b gray=%b wrap=%b, want gray=%b wrap=%b",
                         i, bin, gray, wrap, exp_g[i], exp_w[i]);
            end
        end
    endtask

    task automatic test_down_wrap();
        exp_t x;
        drive(1'b1, 1'b0, 1'b0, 1'b0, '0);
        void'(sb.pop_front());
        drive(1'b0, 1'b0, 1'b1, 1'b0, '0);
        x = sb.pop_front();
        checks++;
        if (bin !== 5'b11111 || gray !== 5'b10000 || wrap !== 1'b1 || {bin, gray, wrap} !== x) begin
            errors++;
            $display("FAIL down_wrap: got bin=%b gray=%b wrap=%b, want 11111/10000/1", bin, gray, wrap);
        end
        drive(1'b0, 1'b0, 1'b1, 1'b0, '0);
        x = sb.pop_front();
        checks++;
        if (bin !== 5'b11110 || gray !== 5'b10001 || wrap !== 1'b0 || {bin, gray, wrap} !== x) begin
            errors++;
            $display("FAIL down_next: got bin=%b gray=%b wrap=%b, want 11110/10001/0", bin, gray, wrap);
        end
    endtask

    task automatic test_load_priority();
        exp_t x;
        drive(1'b0, 1'b1, 1'b1, 1'b1, 5'b10110);
        x = sb.pop_front();
        checks++;
        if (bin !== 5'b10110 || gray !== 5'b11101 || wrap !== 1'b0 || {bin, gray, wrap} !== x) begin
            errors++;
            $display("FAIL load_prio: got bin=%b gray=%b wrap=%b, want 10110/11101/0", bin, gray, wrap);
        end
        // Load of 31 with en/up=1 must not count as a wrap step.
        drive(1'b0, 1'b1, 1'b1, 1'b1, 5'b11111);
        x = sb.pop_front();
        drive(1'b0, 1'b1, 1'b1, 1'b1, 5'b00000);
        x = sb.pop_front();
        checks++;
        if (wrap !== 1'b0 || {bin, gray, wrap} !== x) begin
            errors++;
            $display("FAIL load_nowrap: got bin=%b gray=%b wrap=%b, want 00000/00000/0", bin, gray, wrap);
        end
        // Hold with en=0.
        drive(1'b0, 1'b0, 1'b0, 1'b1, 5'b10101);
        x = sb.pop_front();
        checks++;
        if ({bin, gray, wrap} !== x) begin
            errors++;
            $display("FAIL hold: got %b/%b/%b, want %b/%b/%b", bin, gray, wrap, x.bin, x.gray, x.wrap);
        end
    endtask

    task automatic test_dir_change();
        exp_t x;
        logic [SIZE-1:0] prev;
        logic            dirs [6] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
        drive(1'b0, 1'b1, 1'b0, 1'b0, 5'd5);
        void'(sb.pop_front());
        prev = gray;
        for (int i = 0; i < 6; i++) begin
            drive(1'b0, 1'b0, 1'b1, dirs[i], '0);
            x = sb.pop_front();
            checks++;
            if ({bin, gray, wrap} !== x || $countones(gray ^ prev) != 1) begin
                errors++;
                $display("FAIL dir_change[%0d]: got bin=%b gray=%b prev=%b, want bin=%b gray=%b",
                         i, bin, gray, prev, x.bin, x.gray);
            end
            prev = gray;
        end
    endtask

    task automatic test_round_trip();
        exp_t x;
        logic [SIZE-1:0] prev;
        int wraps = 0;
        int bad   = 0;
        drive(1'b1, 1'b0, 1'b0, 1'b0, '0);
        void'(sb.pop_front());
        prev = gray;
        for (int i = 0; i < 64; i++) begin
            drive(1'b0, 1'b0, 1'b1, 1'b1, '0);
            x = sb.pop_front();
            checks++;
            if ({bin, gray, wrap} !== x || ref_dec(gray) !== bin || $countones(gray ^ prev) != 1) begin
                errors++;
                bad++;
                if (bad < 5)
                    $display("FAIL round_trip[%0d]: got bin=%b gray=%b dec=%b prev=%b, want bin=%b gray=%b",
                             i, bin, gray, ref_dec(gray), prev, x.bin, x.gray);
            end
            if (wrap === 1'b1) wraps++;
            prev = gray;
        end
        checks++;
        if (wraps != 2) begin
            errors++;
            $display("FAIL wrap_count: got %0d pulses, want 2", wraps);
        end
    endtask

    task automatic test_reset_mid();
        exp_t x;
        drive(1'b0, 1'b1, 1'b0, 1'b0, 5'd31);
        void'(sb.pop_front());
        drive(1'b1, 1'b0, 1'b1, 1'b1, '0);
        x = sb.pop_front();
        checks++;
        if (bin !== 5'b0 || gray !== 5'b0 || wrap !== 1'b0 || {bin, gray, wrap} !== x) begin
            errors++;
            $display("FAIL reset_mid: got bin=%b gray=%b wrap=%b, want 00000/00000/0", bin, gray, wrap);
        end
        drive(1'b0, 1'b0, 1'b0, 1'b0, '0);
        x = sb.pop_front();
        checks++;
        if (wrap !== 1'b0 || {bin, gray, wrap} !== x) begin
            errors++;
            $display("FAIL reset_mid_after: got bin=%b gray=%b wrap=%b, want 00000/00000/0", bin, gray, wrap);
        end
    endtask

    initial begin
        @(posedge clk);
        #1;
        test_reset();
        test_up_wrap();
        test_down_wrap();
        test_load_priority();
        test_dir_change();
        test_round_trip();
        test_reset_mid();
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain: got %0d leftover entries, want 0", sb.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/gray_counter.md
# gray_counter

Registered Gray-code counter: an internal binary count is encoded to Gray code each cycle, with successive outputs differing in exactly one bit. It is the encoding-side counterpart of the team's Gray-to-binary decoder. The Gray output feeds pointer-crossing and position-encoder logic, which decode it back to binary with that decoder. Supports up/down counting, a parallel binary load, and a wrap flag.

## Interface
- SIZE, 8, counter and code width in bits (≥2)
- clk  input  1  rising-edge clock
- rst  input  1  synchronous, active-high reset
- en  input  1  count enable; one step per cycle while high
- up  input  1  direction: 1 = increment, 0 = decrement; sampled only when en=1
- load  input  1  parallel-load strobe
- load_bin  input  SIZE  binary value to load
- gray  output  SIZE  registered Gray code of current count
- bin  output  SIZE  registered binary count
- wrap  output  1  registered one-cycle pulse on count wrap-around

## Operation
- State is a binary register cnt[SIZE-1:0].
- Outputs:
  - bin = cnt.
  - gray is a separate register loaded with the encoding of the next cnt value, so gray always matches bin in the same cycle.
- Encoding: gray = next ^ (next >> 1), i.e. gray[SIZE-1] = bin[SIZE-1] and gray[i] = bin[i+1] ^ bin[i].
- Priority per cycle is rst > load > en. Exactly one rule applies:
  - rst=1: cnt←0, gray←0, wrap←0.
  - load=1: cnt←load_bin, gray←enc(load_bin), wrap←0. en and up are ignored.
  - en=1, up=1: cnt←cnt+1, modulo 2^SIZE.
  - en=1, up=0: cnt←cnt−1, modulo 2^SIZE.
  - otherwise: hold; wrap←0.
- Width rule: all arithmetic is SIZE bits, and the carry/borrow is discarded.
- wrap←1 only on an en step that crosses a boundary:
  - up step from 2^SIZE−1 to 0.
  - down step from 0 to 2^SIZE−1.
- Any en step (including wrap steps) changes exactly one bit of gray. A load may change any number of bits.
- Changing direction between consecutive steps is legal; each step is still a single-bit change.

## Timing
- All outputs are registered and update on the rising clk edge after the inputs are sampled. Latency is 1 cycle from en, load or rst to the new outputs.
- Reset value of every output is 0: bin=0, gray=0, wrap=0. This holds from the first edge with rst=1.
- wrap is high for exactly the one cycle that follows the wrapping edge.
  - Continuous counting with SIZE=5 produces one wrap pulse every 32 cycles.
- rst asserted mid-count, including on the cycle of a wrap step or a load, wins. Outputs go to 0 and no wrap pulse is generated.
- load and en both high: the load wins, with no step and no wrap.
- There is no combinational path from any input to any output.

## Structure
- gray_pkg (shared package) holds:
  - function bin2gray(input logic [N-1:0]), parameterised through the caller's SIZE.
  - localparam-free helper max_count(SIZE) = 2^SIZE−1.
- One sub-module is natural: bin2gray #(SIZE), purely combinational, instantiated on the next-count bus to drive the gray register's D input.
  - It is the exact inverse of the existing gray-to-binary decoder and can be unit-tested against it.
- The top level holds the counter register, the next-state mux and the wrap logic.

## Test plan
All scenarios use SIZE=5.
1. Reset: assert rst for 2 cycles with en=1 → bin=00000, gray=00000, wrap=0. The first en step after release gives bin=00001, gray=00001.
2. Up wrap: load 5'd30, then en=1, up=1 for 3 cycles → gray sequence 10001, 10000, 00000, 00001. wrap=1 only in the cycle with gray=00000.
3. Down wrap: from reset, en=1, up=0 → bin=11111, gray=10000, wrap=1. Next cycle gives bin=11110, gray=10001, wrap=0.
4. Load priority: load=1, en=1, load_bin=10110 → bin=10110, gray=11101, wrap=0, no step taken.
5. Round trip: free-run up for 64 cycles with gray fed to the existing gray-to-binary decoder.
   - Decoder output equals bin every cycle.
   - Hamming distance between consecutive gray values is 1.
   - Exactly 2 wrap pulses.
6. Reset mid-operation: assert rst in the cycle cnt=31 is stepping up → outputs 00000/00000 and wrap stays 0.
